// File: rtl/cdm_pkg.sv
// cdm_pkg: shared types and helpers for the row-serial carry-disregard multiplier.
// Optional feature macro used by the design: CDM_EXACT_MODE_EN.
package cdm_pkg;

    // Top-level control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest result column of the carry-propagating region in the final row
    function automatic int cdm_exact_top(input int w, input int exact_cols);
        return w - 1 - exact_cols;
    endfunction

    // Legal parameter space; checked at elaboration by the top level
    function automatic bit cdm_params_ok(input int wa, input int wb, input int exact_cols);
        return (wa >= 2) && (wb >= 2) && (exact_cols >= 0) && (exact_cols <= wa - 1);
    endfunction

endpackage

// File: rtl/cdm_row_step.sv
// cdm_row_step: one accumulate step of the multiplier (combinational).
// Approximate rule: XOR every row; the final row adds with carries only in
// columns [W-1:T]. With CDM_EXACT_MODE_EN defined, exact=1 selects a full add.
module cdm_row_step
    import cdm_pkg::*;
#(
    parameter int W          = 12,
    parameter int EXACT_COLS = 2
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] pp,
    input  logic         is_last,
    input  logic         exact,
    output logic [W-1:0] acc_nxt
);

    localparam int T = cdm_exact_top(W, EXACT_COLS);

    logic [W-1:0]   xor_v;
    logic [W-T-1:0] hi_sum;

    // Carry-free XOR accumulate, with a short carry chain on the last row's top columns
    always_comb begin
        xor_v   = acc ^ pp;
        hi_sum  = acc[W-1:T] + pp[W-1:T];
        acc_nxt = is_last ? {hi_sum, xor_v[T-1:0]} : xor_v;
`ifdef CDM_EXACT_MODE_EN
        if (exact) acc_nxt = acc + pp;
`endif
    end

`ifndef CDM_EXACT_MODE_EN
    // Mode input exists in both builds; without the feature it has no effect
    logic unused_exact;
    assign unused_exact = exact;
`endif

endmodule

// File: rtl/cdm_seq_mult.sv
// cdm_seq_mult: row-serial carry-disregard approximate multiplier with
// valid/ready handshakes. One multiplier row is folded in per clock, so an
// operation takes WB+2 cycles (accept, WB rows, present).
// Optional feature macro: CDM_EXACT_MODE_EN (per-operation exact product).
module cdm_seq_mult
    import cdm_pkg::*;
#(
    parameter int WA         = 8,
    parameter int WB         = 4,
    parameter int EXACT_COLS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WA-1:0]   in_a,
    input  logic [WB-1:0]   in_b,
    input  logic            in_exact,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WA+WB-1:0] out_r
);

    localparam int W  = WA + WB;
    localparam int RW = $clog2(WB);
    localparam logic [RW-1:0] LAST_ROW = RW'(WB - 1);

    generate
        if (!cdm_params_ok(WA, WB, EXACT_COLS)) begin : g_bad_params
            $error("cdm_seq_mult: illegal WA/WB/EXACT_COLS combination");
        end
    endgenerate

    state_t         state, state_nxt;
    logic [WA-1:0]  a_q;
    logic [WB-1:0]  b_q;
    logic           exact_q;
    logic [W-1:0]   acc, acc_nxt, pp;
    logic [RW-1:0]  row;
    logic           is_last;

    assign is_last = (row == LAST_ROW);
    // Rows with a zero multiplier bit still take their cycle (data-independent latency)
    assign pp      = b_q[row] ? (W'(a_q) << row) : '0;
    assign out_r   = acc;

    cdm_row_step #(
        .W          (W),
        .EXACT_COLS (EXACT_COLS)
    ) u_row_step (
        .acc     (acc),
        .pp      (pp),
        .is_last (is_last),
        .exact   (exact_q),
        .acc_nxt (acc_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (is_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept; accumulate and advance row while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            exact_q <= 1'b0;
            acc     <= '0;
            row     <= '0;
        end else if (state == IDLE && in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
`ifdef CDM_EXACT_MODE_EN
            exact_q <= in_exact;
`else
            exact_q <= 1'b0;
`endif
            acc <= '0;
            row <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            // Wrap at the last row so the counter never points past WB-1
            row <= is_last ? '0 : row + RW'(1);
        end
    end

`ifndef CDM_EXACT_MODE_EN
    // Mode request is accepted on the port but ignored in this build
    logic unused_in_exact;
    assign unused_in_exact = in_exact;
`endif

endmodule

// File: tb/tb_cdm_seq_mult.sv
// tb_cdm_seq_mult: scoreboard bench for cdm_seq_mult (default 8x4 instance
// plus a 16x8, EXACT_COLS=4 instance for randomised traffic).
module tb_cdm_seq_mult;

    localparam int WA = 8,  WB = 4, EC = 2,  W = WA + WB;
    localparam int WA2 = 16, WB2 = 8, EC2 = 4, W2 = WA2 + WB2;
`ifdef CDM_EXACT_MODE_EN
    localparam bit EXACT_EN = 1'b1;
`else
    localparam bit EXACT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, in_exact, out_valid, out_ready;
    logic [WA-1:0]   in_a;
    logic [WB-1:0]   in_b;
    logic [W-1:0]    out_r;

    logic            w_in_valid, w_in_ready, w_in_exact, w_out_valid, w_out_ready;
    logic [WA2-1:0]  w_in_a;
    logic [WB2-1:0]  w_in_b;
    logic [W2-1:0]   w_out_r;

    cdm_seq_mult #(.WA(WA), .WB(WB), .EXACT_COLS(EC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r)
    );

    cdm_seq_mult #(.WA(WA2), .WB(WB2), .EXACT_COLS(EC2)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_exact(w_in_exact), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_r(w_out_r)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint unsigned q[$];
    longint unsigned qw[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-level reference of the multiplier rules
    function automatic longint unsigned model(input longint unsigned a, input longint unsigned b,
                                              input bit ex, input int wa, input int wb, input int ec);
        longint unsigned mask, lo_m, acc, pp;
        int w, t;
        w    = wa + wb;
        t    = w - 1 - ec;
        mask = (64'd1 << w) - 1;
        lo_m = (64'd1 << t) - 1;
        acc  = 0;
        for (int k = 0; k < wb; k++) begin
            pp = ((b >> k) & 1) != 0 ? ((a << k) & mask) : 64'd0;
            if (ex)            acc = (acc + pp) & mask;
            else if (k < wb-1) acc = acc ^ pp;
            else               acc = ((acc ^ pp) & lo_m) | ((((acc >> t) + (pp >> t)) << t) & mask);
        end
        return acc;
    endfunction

    task automatic send(input longint unsigned a, input longint unsigned b, input bit ex,
                        input longint unsigned exp);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_a     = a[WA-1:0];
        in_b     = b[WB-1:0];
        in_exact = ex;
        q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_w(input longint unsigned a, input longint unsigned b, input bit ex);
        int guard = 0;
        @(negedge clk);
        while (!w_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!w_in_ready) begin
            chk("w_in_ready_timeout", {63'd0, w_in_ready}, 64'd1);
            return;
        end
        w_in_valid = 1'b1;
        w_in_a     = a[WA2-1:0];
        w_in_b     = b[WB2-1:0];
        w_in_exact = ex;
        qw.push_back(model(a, b, ex && EXACT_EN, WA2, WB2, EC2));
        @(posedge clk);
        #1 w_in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || qw.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_main", 64'(q.size()), 64'd0);
        chk("drain_wide", 64'(qw.size()), 64'd0);
    endtask

    // Result monitors: pop expected value at each output handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_main_nonempty", {63'd0, q.size() > 0}, 64'd1);
            if (q.size() > 0) chk("result", 64'(out_r), q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_out_valid && w_out_ready) begin
            chk("sb_wide_nonempty", {63'd0, qw.size() > 0}, 64'd1);
            if (qw.size() > 0) chk("result_wide", 64'(w_out_r), qw.pop_front());
        end
    end

    // Random back-pressure on the wide instance, changed away from the sampling edge
    always @(posedge clk) begin
        #2 w_out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] held;
        longint unsigned ra, rb;
        bit rx;

        in_valid = 0; in_a = '0; in_b = '0; in_exact = 0; out_ready = 1'b1;
        w_in_valid = 0; w_in_a = '0; w_in_b = '0; w_in_exact = 0; w_out_ready = 1'b1;

        // Reset values
        #1;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_r",     64'(out_r),         64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed approximate products
        send(3, 3, 0, 64'h5);
        send(8'h80, 4'h8, 0, 64'h400);
        send(8'hFF, 4'hF, 0, 64'h905);
        send(8'hFF, 4'hF, 1, EXACT_EN ? 64'hEF1 : 64'h905);
        send(8'h00, 4'hF, 1, 64'h0);
        drain();

        // Latency and back-pressure
        out_ready = 1'b0;
        send(8'h5A, 4'hB, 0, model(8'h5A, 4'hB, 0, WA, WB, EC));
        for (int i = 1; i <= WB; i++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_out_valid_e%0d", i), {63'd0, out_valid}, {63'd0, i == WB});
            chk($sformatf("lat_in_ready_e%0d", i),  {63'd0, in_ready},  64'd0);
        end
        held = out_r;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready",  {63'd0, in_ready},  64'd0);
            chk("bp_out_r",     64'(out_r),         64'(held));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        drain();

        // Reset mid-RUN at row 2: partial result dropped
        send(8'h77, 4'hE, 0, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("midrst_out_r",     64'(out_r),         64'd0);
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 3, 0, 64'h5);
        drain();

        // Random traffic on the default instance, including boundary operands
        for (int n = 0; n < 150; n++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 15);
            if (n % 10 == 0) ra = 255;
            if (n % 15 == 0) rb = 15;
            rx = $urandom_range(0, 1);
            send(ra, rb, rx, model(ra, rb, rx && EXACT_EN, WA, WB, EC));
        end
        drain();

        // Random traffic on the 16x8 instance under random back-pressure
        for (int n = 0; n < 300; n++) begin
            ra = $urandom_range(0, 65535);
            rb = $urandom_range(0, 255);
            if (n % 20 == 0) begin ra = 65535; rb = 255; end
            rx = $urandom_range(0, 1);
            send_w(ra, rb, rx);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
